port_parse: RTL and testbench
=============================

PORT_PARSE -- requirements
Module: port_parse

Interface
REQ-001 Parameter port_num, default 0: source port ID inserted into every parse result.
REQ-002 Parameter port_sz, default 2: width of the port ID field; port_sz = log2(`NUM_PORTS).
REQ-003 clk  input  1  sole clock; all flops on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
REQ-005 rxg_srdy  input  1  byte-stream source ready.
REQ-006 rxg_drdy  output  1  byte-stream destination ready.
REQ-007 rxg_code  input  2  byte code: 2'b01 SOP, 2'b00 MOP, 2'b10 good EOP, 2'b11 bad EOP.
REQ-008 rxg_data  input  8  packet byte.
REQ-009 ppi_srdy  output  1  parse result valid.
REQ-010 ppi_drdy  input  1  parse result accepted.
REQ-011 ppi_data  output  96+port_sz  {port_num, SA[47:0], DA[47:0]}, equal in width to `PAR_DATA_SZ.
REQ-012 pkt_cnt  output  16  count of headers emitted.
REQ-013 runt_cnt  output  16  count of packets discarded before header completion.

Function
REQ-014 A byte transfers when rxg_srdy and rxg_drdy are both 1 on a rising clk edge; a result transfers when ppi_srdy and ppi_drdy are both 1.
REQ-015 The FSM has three states: IDLE, HDR and BODY; reset state is IDLE.
REQ-016 IDLE: an SOP byte is stored as header byte 0 and the FSM moves to HDR; non-SOP bytes are accepted and dropped.
REQ-017 HDR collects bytes 0-11 with a 4-bit byte counter; byte0 -> DA[47:40] ... byte5 -> DA[7:0], byte6 -> SA[47:40] ... byte11 -> SA[7:0].
REQ-018 Byte 11 of a MOP moves HDR to BODY; byte 11 of a good or bad EOP moves HDR to IDLE; in both cases the header is loaded into the output register.
REQ-019 The output register is a single entry; ppi_srdy rises on the cycle after byte 11 transfers and holds until ppi_drdy.
REQ-020 rxg_drdy is 0 only in HDR with counter==11 while ppi_srdy=1 and ppi_drdy=0; it is 1 in all other cases, including a same-cycle drain (full-throughput load).
REQ-021 ppi_data is held stable while ppi_srdy=1 and ppi_drdy=0.
REQ-022 An EOP (good or bad) in HDR with counter<11 discards the partial header, increments runt_cnt and moves to IDLE; no result is emitted.
REQ-023 An SOP in HDR discards the partial header, increments runt_cnt, restarts at byte 0 and stays in HDR.
REQ-024 BODY accepts and drops MOP bytes; a good or bad EOP moves to IDLE; an SOP restarts HDR at byte 0 without affecting runt_cnt.
REQ-025 pkt_cnt increments on each load of the output register.
REQ-026 pkt_cnt and runt_cnt saturate at 16'hFFFF and do not wrap.
REQ-027 Minimum latency from byte 11 transfer to ppi_srdy=1 is 1 cycle; sustained throughput is one byte per cycle.

Reset
REQ-028 Asserting reset (0) immediately forces the FSM to IDLE, clears the counter, ppi_srdy=0, ppi_data=0, pkt_cnt=0 and runt_cnt=0; while reset is asserted, rxg_drdy=1.
REQ-029 A reset asserted mid-packet or with a pending result drops that work silently; after reset, bytes are dropped until the next SOP.

Configuration
REQ-030 Macro PORT_PARSE_STATS_EN defined: pkt_cnt and runt_cnt are implemented as specified in REQ-025 and REQ-026.
REQ-031 Macro PORT_PARSE_STATS_EN undefined: pkt_cnt and runt_cnt are constant 0 with no flops; all other behaviour is identical.

Verification
REQ-032 Bytes 01..0C plus 50 MOP and a good EOP, port_num=2, ppi_drdy=1 -> one result with DA=48'h010203040506, SA=48'h0708090A0B0C and port field 2, 1 cycle after byte 12; pkt_cnt=1.
REQ-033 Exactly 12-byte packet ending in EOP on byte 12 -> one result; FSM in IDLE on the next cycle; next SOP accepted at once.
REQ-034 8-byte packet ending in bad EOP -> no ppi_srdy; runt_cnt=1; pkt_cnt unchanged.
REQ-035 Two back-to-back 12-byte packets with ppi_drdy=0 -> byte 12 of packet 2 stalled (rxg_drdy=0); ppi_data stable; raising ppi_drdy for 1 cycle releases the stall; packet 2's result follows 1 cycle later.
REQ-036 Reset asserted after byte 5 of a packet, then released, then MOP bytes, then a fresh 12-byte packet -> MOP bytes dropped; only the fresh header is emitted; with the macro undefined, both counters read 0 throughout.

Source files
------------

// File: rtl/port_parse.sv
// port_parse: parses a byte stream and emits the 12-byte MAC header as a single result.
// Bytes 0-5 form DA and bytes 6-11 form SA; each result is {port_num, SA, DA}.
//
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   rxg_srdy/rxg_drdy   byte-stream handshake
//   rxg_code/rxg_data   byte code (01 SOP, 00 MOP, 10 good EOP, 11 bad EOP) and byte
//   ppi_srdy/ppi_drdy   parse-result handshake
//   ppi_data            {port_num, SA[47:0], DA[47:0]}
//   pkt_cnt/runt_cnt    saturating counts of emitted headers and runt packets
//
// Macro PORT_PARSE_STATS_EN enables the two statistics counters.
// Without it, both counters are tied to zero.
module port_parse #(
    parameter int port_num = 0,
    parameter int port_sz  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxg_srdy,
    output logic                  rxg_drdy,
    input  logic [1:0]            rxg_code,
    input  logic [7:0]            rxg_data,
    output logic                  ppi_srdy,
    input  logic                  ppi_drdy,
    output logic [96+port_sz-1:0] ppi_data,
    output logic [15:0]           pkt_cnt,
    output logic [15:0]           runt_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [87:0] hdr;
    logic        xfer;
    logic        sop;
    logic        eop;
    logic        load;
    logic [95:0] full;

    assign sop  = (rxg_code == 2'b01);
    assign eop  = rxg_code[1];
    assign xfer = rxg_srdy & rxg_drdy;

    // Stall only the final header byte, and only while the result slot
    // stays occupied this cycle; a same-cycle drain keeps full throughput.
    assign rxg_drdy = !((state == HDR) && (cnt == 4'd11) &&
                        ppi_srdy && !ppi_drdy);

    // Byte 0 ends up in the top byte, so DA sits in the upper half.
    assign full = {hdr, rxg_data};
    assign load = xfer && (state == HDR) && !sop && (cnt == 4'd11);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            hdr      <= '0;
            ppi_srdy <= 1'b0;
            ppi_data <= '0;
        end else begin
            if (ppi_srdy && ppi_drdy)
                ppi_srdy <= 1'b0;
            if (load) begin
                ppi_srdy <= 1'b1;
                ppi_data <= {port_sz'(port_num), full[47:0], full[95:48]};
            end
            if (xfer) begin
                unique case (state)
                    IDLE: begin
                        if (sop) begin
                            hdr   <= {hdr[79:0], rxg_data};
                            cnt   <= 4'd1;
                            state <= HDR;
                        end
                    end
                    HDR: begin
                        if (sop) begin
                            hdr <= {hdr[79:0], rxg_data};
                            cnt <= 4'd1;
                        end else if (cnt == 4'd11) begin
                            cnt   <= 4'd0;
                            state <= eop ? IDLE : BODY;
                        end else if (eop) begin
                            cnt   <= 4'd0;
                            state <= IDLE;
                        end else begin
                            hdr <= {hdr[79:0], rxg_data};
                            cnt <= cnt + 4'd1;
                        end
                    end
                    BODY: begin
                        if (sop) begin
                            hdr   <= {hdr[79:0], rxg_data};
                            cnt   <= 4'd1;
                            state <= HDR;
                        end else if (eop) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef PORT_PARSE_STATS_EN
    logic runt;

    // A runt is any header abandoned early: an EOP before byte 11,
    // or a new SOP arriving while the header is still being collected.
    assign runt = xfer && (state == HDR) &&
                  (sop || (eop && (cnt != 4'd11)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt  <= 16'd0;
            runt_cnt <= 16'd0;
        end else begin
            if (load && (pkt_cnt != 16'hFFFF))
                pkt_cnt <= pkt_cnt + 16'd1;
            if (runt && (runt_cnt != 16'hFFFF))
                runt_cnt <= runt_cnt + 16'd1;
        end
    end
`else
    assign pkt_cnt  = 16'd0;
    assign runt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_port_parse.sv
// tb_port_parse: directed stimulus for port_parse with a result scoreboard.
// The stimulus process queues expected headers; a monitor process compares each accepted result.
module tb_port_parse;

    localparam int PSZ = 2;
    localparam int DW  = 96 + PSZ;

    logic          clk = 1'b0;
    logic          reset;
    logic          rxg_srdy;
    logic          rxg_drdy;
    logic [1:0]    rxg_code;
    logic [7:0]    rxg_data;
    logic          ppi_srdy;
    logic          ppi_drdy;
    logic [DW-1:0] ppi_data;
    logic [15:0]   pkt_cnt;
    logic [15:0]   runt_cnt;

    int n_pass  = 0;
    int n_total = 0;
    int exp_pkt  = 0;
    int exp_runt = 0;

    logic [DW-1:0] exp_q[$];

    port_parse #(.port_num(2), .port_sz(PSZ)) dut (
        .clk      (clk),
        .reset    (reset),
        .rxg_srdy (rxg_srdy),
        .rxg_drdy (rxg_drdy),
        .rxg_code (rxg_code),
        .rxg_data (rxg_data),
        .ppi_srdy (ppi_srdy),
        .ppi_drdy (ppi_drdy),
        .ppi_data (ppi_data),
        .pkt_cnt  (pkt_cnt),
        .runt_cnt (runt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_cnts(input string nm);
`ifdef PORT_PARSE_STATS_EN
        chk({nm, "_pkt_cnt"}, 128'(pkt_cnt), 128'(exp_pkt));
        chk({nm, "_runt_cnt"}, 128'(runt_cnt), 128'(exp_runt));
`else
        chk({nm, "_pkt_cnt"}, 128'(pkt_cnt), 128'd0);
        chk({nm, "_runt_cnt"}, 128'(runt_cnt), 128'd0);
`endif
    endtask

    // Monitor: a result is accepted at the posedge following this negedge.
    always @(negedge clk) begin
        if (reset && ppi_srdy && ppi_drdy) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got %0h expected none",
                         ppi_data);
            end else begin
                chk("result", 128'(ppi_data), 128'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [DW-1:0] hdr_exp(input logic [7:0] base);
        logic [47:0] da;
        logic [47:0] sa;
        da = '0;
        sa = '0;
        for (int i = 0; i < 6; i++) begin
            da = {da[39:0], 8'(base + 8'(i))};
            sa = {sa[39:0], 8'(base + 8'(i + 6))};
        end
        return {2'd2, sa, da};
    endfunction

    // Called just after a posedge; returns just after the transferring posedge.
    task automatic send(input logic [1:0] c, input logic [7:0] d);
        int waits;
        waits = 0;
        rxg_srdy = 1'b1;
        rxg_code = c;
        rxg_data = d;
        @(negedge clk);
        while (!rxg_drdy && waits <= 20) begin
            waits++;
            @(negedge clk);
        end
        if (!rxg_drdy) begin
            n_total++;
            $display("FAIL send_timeout: got drdy=0 expected drdy=1");
        end
        @(posedge clk);
        #1;
        rxg_srdy = 1'b0;
    endtask

    // Full-header packet: bytes base..base+11, then nmop body bytes,
    // then an optional terminating EOP.
    task automatic send_pkt(input logic [7:0] base, input int nmop,
                            input bit term, input logic [1:0] ecode);
        exp_q.push_back(hdr_exp(base));
        exp_pkt++;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)
                send(2'b01, base);
            else if (i == 11 && nmop == 0 && term)
                send(ecode, 8'(base + 8'(i)));
            else
                send(2'b00, 8'(base + 8'(i)));
        end
        chk("latency_srdy", 128'(ppi_srdy), 128'd1);
        for (int i = 0; i < nmop; i++)
            send(2'b00, 8'(8'hE0 + 8'(i)));
        if (term && nmop != 0)
            send(ecode, 8'hEE);
    endtask

    initial begin
        logic [DW-1:0] da_a;
        logic [DW-1:0] da_b;
        reset    = 1'b0;
        rxg_srdy = 1'b0;
        rxg_code = 2'b00;
        rxg_data = 8'h00;
        ppi_drdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_srdy", 128'(ppi_srdy), 128'd0);
        chk("rst_data", 128'(ppi_data), 128'd0);
        chk("rst_drdy", 128'(rxg_drdy), 128'd1);
        chk_cnts("rst");
        @(posedge clk);
        #1;
        reset    = 1'b1;
        ppi_drdy = 1'b1;

        // Non-SOP bytes in IDLE are dropped.
        send(2'b00, 8'hAA);
        send(2'b10, 8'hBB);
        @(negedge clk);
        chk("idle_drop_srdy", 128'(ppi_srdy), 128'd0);
        @(posedge clk);
        #1;

        // 12 header bytes, 50 body bytes, good EOP.
        send_pkt(8'h01, 50, 1'b1, 2'b10);
        chk("vec_hdr", 128'(hdr_exp(8'h01)),
            128'({2'd2, 48'h0708090A0B0C, 48'h010203040506}));
        chk_cnts("pkt1");

        // Exact 12-byte packets back to back; bad EOP on byte 11 still emits.
        send_pkt(8'h20, 0, 1'b1, 2'b10);
        send_pkt(8'h40, 0, 1'b1, 2'b11);
        chk_cnts("exact12");

        // 8-byte packet ending in bad EOP is a runt.
        send(2'b01, 8'h60);
        for (int i = 1; i < 7; i++) send(2'b00, 8'(8'h60 + 8'(i)));
        send(2'b11, 8'h67);
        exp_runt++;
        @(negedge clk);
        chk("runt8_srdy", 128'(ppi_srdy), 128'd0);
        chk_cnts("runt8");
        @(posedge clk);
        #1;

        // SOP inside a partial header restarts it.
        send(2'b01, 8'h55);
        for (int i = 0; i < 3; i++) send(2'b00, 8'h56);
        exp_runt++;
        send_pkt(8'h70, 2, 1'b1, 2'b10);
        chk_cnts("hdr_sop");

        // SOP in BODY restarts the header without counting a runt.
        send_pkt(8'h80, 3, 1'b0, 2'b10);
        send_pkt(8'h90, 0, 1'b1, 2'b10);
        chk_cnts("body_sop");

        // EOP as the 11th byte (one short) is a runt.
        send(2'b01, 8'h33);
        for (int i = 0; i < 9; i++) send(2'b00, 8'h34);
        send(2'b10, 8'h35);
        exp_runt++;
        @(negedge clk);
        chk("runt11_srdy", 128'(ppi_srdy), 128'd0);
        chk_cnts("runt11");
        @(posedge clk);
        #1;

        // Back-pressure: second packet's last header byte stalls.
        ppi_drdy = 1'b0;
        da_a = hdr_exp(8'hA0);
        da_b = hdr_exp(8'hB0);
        send_pkt(8'hA0, 0, 1'b1, 2'b10);
        exp_q.push_back(da_b);
        send(2'b01, 8'hB0);
        for (int i = 1; i < 11; i++) send(2'b00, 8'(8'hB0 + 8'(i)));
        rxg_srdy = 1'b1;
        rxg_code = 2'b10;
        rxg_data = 8'hBB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_drdy", 128'(rxg_drdy), 128'd0);
            chk("stall_data", 128'(ppi_data), 128'(da_a));
            @(posedge clk);
            #1;
        end
        ppi_drdy = 1'b1;
        @(negedge clk);
        chk("release_drdy", 128'(rxg_drdy), 128'd1);
        @(posedge clk);
        #1;
        ppi_drdy = 1'b0;
        rxg_srdy = 1'b0;
        exp_pkt++;
        chk("pkt2_srdy", 128'(ppi_srdy), 128'd1);
        chk("pkt2_data", 128'(ppi_data), 128'(da_b));
        chk_cnts("stall");
        ppi_drdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-header, then stray MOPs, then a fresh packet.
        send(2'b01, 8'hC0);
        for (int i = 1; i < 5; i++) send(2'b00, 8'(8'hC0 + 8'(i)));
        reset = 1'b0;
        exp_pkt  = 0;
        exp_runt = 0;
        @(negedge clk);
        chk("mid_rst_srdy", 128'(ppi_srdy), 128'd0);
        chk("mid_rst_data", 128'(ppi_data), 128'd0);
        chk("mid_rst_drdy", 128'(rxg_drdy), 128'd1);
        chk_cnts("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) send(2'b00, 8'(8'hC5 + 8'(i)));
        @(negedge clk);
        chk("post_rst_drop", 128'(ppi_srdy), 128'd0);
        chk_cnts("post_rst_drop");
        @(posedge clk);
        #1;
        send_pkt(8'hD0, 0, 1'b1, 2'b10);
        chk_cnts("post_rst_pkt");

        repeat (4) @(posedge clk);
        #1;
        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
